// File: rtl/key_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_tracker_pkg
//  Description : Shared definitions for the keyboard key-state tracker:
//                scan-code prefix bytes, modifier key codes, parser state
//                encodings, the Pause skip length and a bitmap index helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package key_tracker_pkg;

    // Scan-code prefix bytes
    localparam logic [7:0] c_PFX_E0 = 8'hE0;  // extended key follows
    localparam logic [7:0] c_PFX_E1 = 8'hE1;  // Pause sequence follows
    localparam logic [7:0] c_PFX_F0 = 8'hF0;  // break (release) follows

    // Modifier key codes (set 2)
    localparam logic [7:0] c_KEY_LALT   = 8'h11;
    localparam logic [7:0] c_KEY_LSHIFT = 8'h12;
    localparam logic [7:0] c_KEY_LCTRL  = 8'h14;
    localparam logic [7:0] c_KEY_CAPS   = 8'h58;
    localparam logic [7:0] c_KEY_RSHIFT = 8'h59;

    // Parser FSM state encodings
    localparam int         c_ST_W      = 3;
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_EXT    = 3'd1;
    localparam logic [2:0] c_ST_BRK    = 3'd2;
    localparam logic [2:0] c_ST_EXTBRK = 3'd3;
    localparam logic [2:0] c_ST_SKIP   = 3'd4;

    // Bytes swallowed after the E1 that opens the Pause sequence
    localparam int         c_SKIP_W     = 3;
    localparam logic [2:0] c_PAUSE_SKIP = 3'd7;

    // Bitmap index is {ext, code[6:0]}; codes with bit7 set never reach it
    function automatic logic [7:0] key_index(input logic ext, input logic [6:0] code);
        return {ext, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fifo
//  Description : Synchronous FIFO for key make events. A push while full is
//                accepted only when a pop happens on the same edge; a pop
//                while empty is ignored.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                i_push/i_push_data - write strobe and data
//                i_pop              - read strobe (head advances)
//                o_head             - current head entry
//                o_full/o_empty     - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = 1;

    // Pointers carry one extra wrap bit to tell full from empty
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_do_pop;
    logic              w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Storage is cleared so the head reads zero after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : key_tracker
//  Description : Parses a PS/2 set-2 scan-code byte stream (E0/F0/E1
//                prefixes), keeps a 256-bit pressed-key bitmap, counts fresh
//                makes, derives shift/ctrl/alt/caps and queues fresh make
//                events as {ext, code[6:0]}.
//  Ports       : clk, clr            - clock, asynchronous active-high reset
//                in_valid, in_data   - received byte strobe and value
//                press_cnt           - wrapping count of fresh makes
//                shift, ctrl, alt    - modifier held flags
//                caps                - Caps Lock toggle state
//                evt_valid/evt_data/evt_ready - event queue handshake
//                overflow            - sticky, event dropped on full queue
//  Revision    : 1.0 - initial release
// ============================================================================
module key_tracker
    import key_tracker_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic [CNT_W-1:0] press_cnt,
    output logic             shift,
    output logic             ctrl,
    output logic             alt,
    output logic             caps,
    output logic             evt_valid,
    output logic [7:0]       evt_data,
    input  logic             evt_ready,
    output logic             overflow
);

    localparam logic [7:0] c_IDX_LSHIFT = {1'b0, c_KEY_LSHIFT[6:0]};
    localparam logic [7:0] c_IDX_RSHIFT = {1'b0, c_KEY_RSHIFT[6:0]};
    localparam logic [7:0] c_IDX_LCTRL  = {1'b0, c_KEY_LCTRL[6:0]};
    localparam logic [7:0] c_IDX_RCTRL  = {1'b1, c_KEY_LCTRL[6:0]};
    localparam logic [7:0] c_IDX_LALT   = {1'b0, c_KEY_LALT[6:0]};
    localparam logic [7:0] c_IDX_RALT   = {1'b1, c_KEY_LALT[6:0]};
    localparam logic [7:0] c_IDX_CAPS   = {1'b0, c_KEY_CAPS[6:0]};

    logic [c_ST_W-1:0]   r_state;
    logic [c_ST_W-1:0]   w_state_nxt;
    logic [c_SKIP_W-1:0] r_skip_cnt;
    logic                w_key_byte;
    logic                w_key_ext;
    logic                w_key_brk;
    logic                w_key_valid;
    logic [7:0]          w_idx;
    logic                w_fresh;
    logic [255:0]        r_bitmap;
    logic [CNT_W-1:0]    r_press_cnt;
    logic                r_caps;
    logic                r_shift;
    logic                r_ctrl;
    logic                r_alt;
    logic                r_overflow;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;

    // ---------------- Parser FSM: state register ----------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- Parser FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (in_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    if      (in_data == c_PFX_E0) w_state_nxt = c_ST_EXT;
                    else if (in_data == c_PFX_F0) w_state_nxt = c_ST_BRK;
                    else if (in_data == c_PFX_E1) w_state_nxt = c_ST_SKIP;
                    else                          w_state_nxt = c_ST_IDLE;
                end
                c_ST_EXT: begin
                    if (in_data == c_PFX_F0) w_state_nxt = c_ST_EXTBRK;
                    else                     w_state_nxt = c_ST_IDLE;
                end
                // Leave once this byte takes the counter to zero
                c_ST_SKIP: begin
                    if (r_skip_cnt <= c_SKIP_W'(1)) w_state_nxt = c_ST_IDLE;
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // ---------------- Parser FSM: outputs ----------------
    always_comb begin
        w_key_byte = 1'b0;
        w_key_ext  = 1'b0;
        w_key_brk  = 1'b0;
        if (in_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_key_byte = (in_data != c_PFX_E0) && (in_data != c_PFX_F0) &&
                                 (in_data != c_PFX_E1);
                end
                c_ST_EXT: begin
                    w_key_byte = (in_data != c_PFX_F0);
                    w_key_ext  = 1'b1;
                end
                c_ST_BRK: begin
                    w_key_byte = 1'b1;
                    w_key_brk  = 1'b1;
                end
                c_ST_EXTBRK: begin
                    w_key_byte = 1'b1;
                    w_key_ext  = 1'b1;
                    w_key_brk  = 1'b1;
                end
                default: begin
                    w_key_byte = 1'b0;
                end
            endcase
        end
    end

    // Acks, errors and 00 are key-position bytes that are simply dropped
    assign w_key_valid = w_key_byte && !in_data[7] && (in_data != 8'h00);
    assign w_idx       = key_index(w_key_ext, in_data[6:0]);
    assign w_fresh     = w_key_valid && !w_key_brk && !r_bitmap[w_idx];
    assign w_pop       = evt_ready && !w_fifo_empty;

    // Pause skip counter
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_skip_cnt <= '0;
        end else if (in_valid) begin
            if (r_state == c_ST_IDLE && in_data == c_PFX_E1)
                r_skip_cnt <= c_PAUSE_SKIP;
            else if (r_state == c_ST_SKIP && r_skip_cnt != '0)
                r_skip_cnt <= r_skip_cnt - c_SKIP_W'(1);
        end
    end

    // Bitmap, press counter, caps and overflow
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_bitmap    <= '0;
            r_press_cnt <= '0;
            r_caps      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_fresh) begin
                r_bitmap[w_idx] <= 1'b1;
                r_press_cnt     <= r_press_cnt + CNT_W'(1);
                if (w_idx == c_IDX_CAPS) r_caps <= ~r_caps;
                if (w_fifo_full && !w_pop) r_overflow <= 1'b1;
            end else if (w_key_valid && w_key_brk) begin
                r_bitmap[w_idx] <= 1'b0;
            end
        end
    end

    // Modifiers sample the bitmap, so they trail it by one edge
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_shift <= 1'b0;
            r_ctrl  <= 1'b0;
            r_alt   <= 1'b0;
        end else begin
            r_shift <= r_bitmap[c_IDX_LSHIFT] | r_bitmap[c_IDX_RSHIFT];
            r_ctrl  <= r_bitmap[c_IDX_LCTRL]  | r_bitmap[c_IDX_RCTRL];
            r_alt   <= r_bitmap[c_IDX_LALT]   | r_bitmap[c_IDX_RALT];
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (clr),
        .i_push      (w_fresh),
        .i_push_data (w_idx),
        .i_pop       (w_pop),
        .o_head      (evt_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign press_cnt = r_press_cnt;
    assign shift     = r_shift;
    assign ctrl      = r_ctrl;
    assign alt       = r_alt;
    assign caps      = r_caps;
    assign overflow  = r_overflow;
    assign evt_valid = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_tracker
//  Description : Directed self-checking bench for key_tracker. Expected make
//                events are queued when the stimulus is driven and compared
//                as the consumer pops them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_tracker;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       evt_ready = 1'b0;
    logic [7:0] press_cnt;
    logic       shift;
    logic       ctrl;
    logic       alt;
    logic       caps;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic       overflow;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    logic [7:0] sb [$];

    key_tracker #(
        .CNT_W (8),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .press_cnt (press_cnt),
        .shift     (shift),
        .ctrl      (ctrl),
        .alt       (alt),
        .caps      (caps),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ready (evt_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte presented at a falling edge, captured at the next rising edge;
    // consecutive calls give back-to-back strobes
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    // Drop the strobe, then allow one more edge for the modifier registers
    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Called on a falling edge: compare head against the scoreboard, then pop
    task automatic pop_check(input string tag);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, evt_valid}, 32'd1);
            chk({tag, "_data"}, {24'd0, evt_data}, {24'd0, exp});
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr      = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        // ---- Reset state ----
        do_reset();
        chk("rst_cnt",   {24'd0, press_cnt}, 32'd0);
        chk("rst_mods",  {29'd0, shift, ctrl, alt}, 32'd0);
        chk("rst_caps",  {31'd0, caps}, 32'd0);
        chk("rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_data",  {24'd0, evt_data}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);

        // ---- Make / break ----
        send(8'h1C); sb.push_back(8'h1C);
        send(8'hF0); send(8'h1C);
        settle();
        chk("mk_cnt", {24'd0, press_cnt}, 32'd1);
        pop_check("mk_evt");
        chk("mk_empty", {31'd0, evt_valid}, 32'd0);
        // Bit cleared by the break: the same key is fresh again
        send(8'h1C); sb.push_back(8'h1C);
        settle();
        chk("remk_cnt", {24'd0, press_cnt}, 32'd2);
        pop_check("remk_evt");
        send(8'hF0); send(8'h1C);
        settle();

        // ---- Typematic repeat ----
        send(8'h1C); sb.push_back(8'h1C);
        send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C);
        settle();
        chk("rep_cnt", {24'd0, press_cnt}, 32'd3);
        pop_check("rep_evt");
        chk("rep_empty", {31'd0, evt_valid}, 32'd0);

        // ---- Right ctrl / left ctrl ----
        send(8'hE0); send(8'h14); sb.push_back(8'h94);
        settle();
        chk("rctrl_on", {31'd0, ctrl}, 32'd1);
        send(8'h14); sb.push_back(8'h14);
        send(8'hF0); send(8'h14);
        settle();
        chk("lctrl_rel", {31'd0, ctrl}, 32'd1);
        send(8'hE0); send(8'hF0); send(8'h14);
        settle();
        chk("rctrl_off", {31'd0, ctrl}, 32'd0);
        chk("ctrl_cnt", {24'd0, press_cnt}, 32'd5);
        pop_check("ctrl_evt0");
        pop_check("ctrl_evt1");

        // ---- Shift and alt ----
        send(8'h12); sb.push_back(8'h12);
        settle();
        chk("lshift_on", {31'd0, shift}, 32'd1);
        send(8'hF0); send(8'h12);
        send(8'h59); sb.push_back(8'h59);
        settle();
        chk("rshift_on", {31'd0, shift}, 32'd1);
        send(8'hF0); send(8'h59);
        send(8'hE0); send(8'h11); sb.push_back(8'h91);
        settle();
        chk("shift_off", {31'd0, shift}, 32'd0);
        chk("ralt_on",   {31'd0, alt}, 32'd1);
        send(8'hE0); send(8'hF0); send(8'h11);
        send(8'h11); sb.push_back(8'h11);
        settle();
        chk("lalt_on", {31'd0, alt}, 32'd1);
        send(8'hF0); send(8'h11);
        settle();
        chk("alt_off", {31'd0, alt}, 32'd0);
        chk("mod_cnt", {24'd0, press_cnt}, 32'd9);
        pop_check("mod_evt0");
        pop_check("mod_evt1");
        pop_check("mod_evt2");
        pop_check("mod_evt3");

        // ---- Caps Lock toggle ----
        send(8'h58); sb.push_back(8'h58);
        settle();
        chk("caps_on", {31'd0, caps}, 32'd1);
        send(8'hF0); send(8'h58);
        send(8'h58); sb.push_back(8'h58);
        send(8'hF0); send(8'h58);
        settle();
        chk("caps_off", {31'd0, caps}, 32'd0);
        chk("caps_cnt", {24'd0, press_cnt}, 32'd11);
        pop_check("caps_evt0");
        pop_check("caps_evt1");

        // ---- Non-key bytes are dropped ----
        send(8'hAA); send(8'h00); send(8'hFA); send(8'hE0); send(8'h00);
        send(8'h83);
        settle();
        chk("junk_cnt",   {24'd0, press_cnt}, 32'd11);
        chk("junk_valid", {31'd0, evt_valid}, 32'd0);

        // ---- Pause sequence swallowed ----
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C); sb.push_back(8'h1C);
        settle();
        chk("pause_cnt",  {24'd0, press_cnt}, 32'd12);
        chk("pause_ctrl", {31'd0, ctrl}, 32'd0);
        pop_check("pause_evt");
        chk("pause_empty", {31'd0, evt_valid}, 32'd0);
        send(8'hF0); send(8'h1C);
        settle();

        // ---- Overflow: nine makes, no consumer ----
        send(8'h15); sb.push_back(8'h15);
        send(8'h1D); sb.push_back(8'h1D);
        send(8'h24); sb.push_back(8'h24);
        send(8'h2D); sb.push_back(8'h2D);
        send(8'h2C); sb.push_back(8'h2C);
        send(8'h35); sb.push_back(8'h35);
        send(8'h3C); sb.push_back(8'h3C);
        settle();
        chk("ovf_pre", {31'd0, overflow}, 32'd0);
        send(8'h43); sb.push_back(8'h43);
        settle();
        chk("ovf_full_ok", {31'd0, overflow}, 32'd0);
        send(8'h44);
        settle();
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_cnt", {24'd0, press_cnt}, 32'd21);
        for (int i = 0; i < 8; i++) pop_check("ovf_evt");
        chk("ovf_drained", {31'd0, evt_valid}, 32'd0);
        chk("ovf_sticky",  {31'd0, overflow}, 32'd1);

        // ---- Reset mid-prefix ----
        send(8'h58); send(8'h12); send(8'hE0);
        settle();
        chk("pre_rst_caps", {31'd0, caps}, 32'd1);
        do_reset();
        chk("mid_rst_cnt",   {24'd0, press_cnt}, 32'd0);
        chk("mid_rst_mods",  {28'd0, shift, ctrl, alt, caps}, 32'd0);
        chk("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("mid_rst_data",  {24'd0, evt_data}, 32'd0);
        chk("mid_rst_ovf",   {31'd0, overflow}, 32'd0);
        send(8'h14); sb.push_back(8'h14);
        settle();
        chk("post_rst_cnt",  {24'd0, press_cnt}, 32'd1);
        chk("post_rst_ctrl", {31'd0, ctrl}, 32'd1);
        pop_check("post_rst_evt");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
